// File: rtl/word_rotate_ctrl_if.sv
// Control/status bundle between the scroll controller and its user.
// The slave side is the rotate controller; the master side drives run/dir/step/load.
interface word_rotate_ctrl_if;
    logic       run;
    logic       dir;
    logic       step;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] sel;
    logic       tick;
    logic       wrap;

    modport master (
        output run, dir, step, load, load_val,
        input  sel, tick, wrap
    );

    modport slave (
        input  run, dir, step, load, load_val,
        output sel, tick, wrap
    );
endinterface

// File: rtl/word_rotate_ctrl.sv
// Scrolling character-position select for the 8-to-1 character mux.
// A programmable prescaler generates auto-advance steps while running;
// a debounced step level adds manual advances on its rising edge, and a
// synchronous load overrides both. sel, tick and wrap are all registered.
module word_rotate_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned N_POS    = 6
) (
    input  logic               Clock,
    input  logic               Resetn,
    word_rotate_ctrl_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]    LAST  = 3'(N_POS - 1);
    localparam logic [3:0]    NPOS4 = 4'(N_POS);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          step_q;

    logic          cnt_en;
    logic          terminal;
    logic          step_edge;
    logic          advance;
    logic          at_edge;
    logic [2:0]    next_sel;

    // Run/hold state register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, prescaler, advance selection and registered-output next values.
    // The prescaler is gated by the state being entered, so a change on run
    // affects counting on the very edge where it is sampled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (bus.run)  state_d = RUNNING;
            RUNNING: if (!bus.run) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase

        cnt_en    = (state_d == RUNNING);
        terminal  = cnt_en && (pcnt_q == PLAST);
        step_edge = bus.step & ~step_q;
        advance   = terminal | step_edge;

        if (bus.dir) begin
            at_edge  = (sel_q == 3'd0);
            next_sel = at_edge ? LAST : sel_q - 3'd1;
        end else begin
            at_edge  = (sel_q == LAST);
            next_sel = at_edge ? 3'd0 : sel_q + 3'd1;
        end

        pcnt_d = pcnt_q;
        sel_d  = sel_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;

        if (cnt_en) begin
            pcnt_d = terminal ? '0 : pcnt_q + PW'(1);
        end

        if (bus.load) begin
            sel_d  = ({1'b0, bus.load_val} < NPOS4) ? bus.load_val : 3'd0;
            pcnt_d = '0;
        end else if (advance) begin
            sel_d  = next_sel;
            wrap_d = at_edge;
            tick_d = terminal;
        end
    end

    // Datapath registers; step_q resets high so a step held through reset is ignored.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pcnt_q <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            step_q <= 1'b1;
        end else begin
            pcnt_q <= pcnt_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            step_q <= bus.step;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;

endmodule
